// File: rtl/gf180_sim_pkg.sv
// Shared encodings for the GF180 scan-flop bank simulation model:
// async set/clear priority, scan direction and per-bit async resolution.
package gf180_sim_pkg;

    // Which per-bit async input wins when CLRN and SETN are both asserted.
    localparam int PRIO_CLR = 0;
    localparam int PRIO_SET = 1;

    // Scan shift direction through the bank.
    localparam int SHIFT_MSB = 0;  // SI -> Q[0], SO = Q[WIDTH-1]
    localparam int SHIFT_LSB = 1;  // SI -> Q[WIDTH-1], SO = Q[0]

    // Resolved asynchronous state of a single flop.
    typedef enum logic [1:0] {
        ASYNC_NONE   = 2'd0,
        ASYNC_FORCE0 = 2'd1,
        ASYNC_FORCE1 = 2'd2
    } async_force_e;

    // Resolve one bit's active-low clear/set pair into a forced value.
    function automatic async_force_e resolve_async(
        input logic clrn,
        input logic setn,
        input int   prio
    );
        async_force_e res;
        res = ASYNC_NONE;
        if (!clrn && !setn) begin
            res = (prio == PRIO_SET) ? ASYNC_FORCE1 : ASYNC_FORCE0;
        end else if (!clrn) begin
            res = ASYNC_FORCE0;
        end else if (!setn) begin
            res = ASYNC_FORCE1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gf180_sim_icg_latch.sv
// Integrated clock gate: low-transparent enable latch plus AND gate.
// The latch is cleared asynchronously by RN so the gated clock is
// quiet for the whole reset period.
module gf180_sim_icg_latch
    import gf180_sim_pkg::*;
(
    input  logic CK,
    input  logic RN,
    input  logic EN,
    output logic GCK
);

    logic r_en_lat;

    // Enable latch: follows EN while CK is low, frozen while CK is high.
    // NOTE: this latch is intentional (always_latch); it is what keeps
    // enable glitches during the high phase off the gated clock.
    always_latch begin
        if (!RN) begin
            r_en_lat <= 1'b0;
        end else if (!CK) begin
            r_en_lat <= EN;
        end
    end

    assign GCK = CK & r_en_lat;

endmodule

// File: rtl/gf180_sim_sdff_bank.sv
// Behavioural model of a WIDTH-bit bank of GF180 scan flops with enable,
// per-bit async set/clear, global async reset and an integrated clock gate.
// The flops are clocked from the gated clock, so an edge only reaches the
// array when the latched enable (E | SE) was high during the low phase.
module gf180_sim_sdff_bank
    import gf180_sim_pkg::*;
#(
    parameter int              WIDTH       = 8,
    parameter int              PRESET_PRIO = PRIO_CLR,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int              SCAN_DIR    = SHIFT_MSB
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [WIDTH-1:0] CLRN,
    input  logic [WIDTH-1:0] SETN,
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic             SE,
    input  logic             SI,
    input  logic             NOTIFIER,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             GCK
);

    logic             w_clk_en;
    logic             w_gck;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_shift_in;
    logic             w_unused_notifier;

    // Timing-check notifier has no functional effect on the model.
    assign w_unused_notifier = NOTIFIER;

    // Scan enable overrides the functional enable, so either opens the gate.
    assign w_clk_en = E | SE;

    gf180_sim_icg_latch u_icg (
        .CK  (CK),
        .RN  (RN),
        .EN  (w_clk_en),
        .GCK (w_gck)
    );

    assign GCK = w_gck;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            logic r_q;

            // Scan chain wiring: SI feeds the end bit the chain shifts away from.
            if (SCAN_DIR == SHIFT_LSB) begin : g_lsb
                if (i == WIDTH - 1) begin : g_end
                    assign w_shift_in[i] = SI;
                end else begin : g_mid
                    assign w_shift_in[i] = w_q[i+1];
                end
            end else begin : g_msb
                if (i == 0) begin : g_end
                    assign w_shift_in[i] = SI;
                end else begin : g_mid
                    assign w_shift_in[i] = w_q[i-1];
                end
            end

            // Per-bit flop: global reset, then set/clear, then gated-clock update.
            // NOTE: the async state is resolved inside the block, not through a
            // continuous assign, so the value seen on a CLRN/SETN edge is never
            // stale; state updates are non-blocking so all bits shift together.
            always_ff @(posedge w_gck or negedge RN or negedge CLRN[i] or negedge SETN[i]) begin
                if (!RN) begin
                    r_q <= RESET_VAL[i];
                end else begin
                    case (resolve_async(CLRN[i], SETN[i], PRESET_PRIO))
                        ASYNC_FORCE0: r_q <= 1'b0;
                        ASYNC_FORCE1: r_q <= 1'b1;
                        default: begin
                            if (SE) begin
                                r_q <= w_shift_in[i];
                            end else begin
                                r_q <= D[i];
                            end
                        end
                    endcase
                end
            end

            assign w_q[i] = r_q;
        end
    endgenerate

    assign Q  = w_q;
    assign SO = (SCAN_DIR == SHIFT_LSB) ? w_q[0] : w_q[WIDTH-1];

endmodule

// File: tb/tb_gf180_sim_sdff_bank.sv
// Directed self-checking bench for gf180_sim_sdff_bank.
// dut0: clear-wins, shift toward MSB. dut1: set-wins, shift toward LSB.
// dut2: single-bit bank shifting toward LSB.
module tb_gf180_sim_sdff_bank;

    localparam logic [7:0] RST_VAL = 8'hA5;

    logic       CK;
    logic       RN;
    logic [7:0] CLRN;
    logic [7:0] SETN;
    logic       E;
    logic [7:0] D;
    logic       SE;
    logic       SI;
    logic       NOTIFIER;
    logic [0:0] clrn2;
    logic [0:0] setn2;

    logic [7:0] q0, q1;
    logic       so0, so1, gck0, gck1;
    logic [0:0] q2;
    logic       so2, gck2;

    int checks;
    int errors;
    int gck_pulses;

    gf180_sim_sdff_bank #(
        .WIDTH(8), .PRESET_PRIO(0), .RESET_VAL(RST_VAL), .SCAN_DIR(0)
    ) dut0 (
        .CK(CK), .RN(RN), .CLRN(CLRN), .SETN(SETN), .E(E), .D(D), .SE(SE),
        .SI(SI), .NOTIFIER(NOTIFIER), .Q(q0), .SO(so0), .GCK(gck0)
    );

    gf180_sim_sdff_bank #(
        .WIDTH(8), .PRESET_PRIO(1), .RESET_VAL(RST_VAL), .SCAN_DIR(1)
    ) dut1 (
        .CK(CK), .RN(RN), .CLRN(CLRN), .SETN(SETN), .E(E), .D(D), .SE(SE),
        .SI(SI), .NOTIFIER(NOTIFIER), .Q(q1), .SO(so1), .GCK(gck1)
    );

    gf180_sim_sdff_bank #(
        .WIDTH(1), .PRESET_PRIO(0), .RESET_VAL(1'b1), .SCAN_DIR(1)
    ) dut2 (
        .CK(CK), .RN(RN), .CLRN(clrn2), .SETN(setn2), .E(E), .D(D[0:0]), .SE(SE),
        .SI(SI), .NOTIFIER(NOTIFIER), .Q(q2), .SO(so2), .GCK(gck2)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial gck_pulses = 0;
    always @(posedge gck0) gck_pulses <= gck_pulses + 1;

    initial begin
        #20000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic test_reset;
        @(negedge CK);
        E = 1'b1; D = 8'h3C; SE = 1'b0;
        @(posedge CK); #2;
        checks++;
        if (gck0 !== 1'b1) begin errors++; $display("FAIL reset_pre_gck: got %b expected 1", gck0); end
        // Assert reset mid high phase: state and gated clock drop at once.
        RN = 1'b0; #1;
        checks++;
        if (q0 !== RST_VAL) begin errors++; $display("FAIL reset_q0: got %h expected %h", q0, RST_VAL); end
        checks++;
        if (q1 !== RST_VAL) begin errors++; $display("FAIL reset_q1: got %h expected %h", q1, RST_VAL); end
        checks++;
        if (q2 !== 1'b1) begin errors++; $display("FAIL reset_q2: got %b expected 1", q2); end
        checks++;
        if (gck0 !== 1'b0 || gck1 !== 1'b0) begin errors++; $display("FAIL reset_gck: got %b%b expected 00", gck0, gck1); end
        checks++;
        if (so0 !== 1'b1 || so1 !== 1'b1) begin errors++; $display("FAIL reset_so: got %b%b expected 11", so0, so1); end
        // Release exactly on a rising edge: that edge must not capture.
        @(posedge CK);
        RN = 1'b1;
        #1;
        checks++;
        if (q0 !== RST_VAL || q1 !== RST_VAL) begin errors++; $display("FAIL reset_release_edge: got %h/%h expected %h", q0, q1, RST_VAL); end
        @(posedge CK); #1;
        checks++;
        if (q0 !== 8'h3C || q1 !== 8'h3C) begin errors++; $display("FAIL reset_first_capture: got %h/%h expected 3c", q0, q1); end
        checks++;
        if (q2 !== 1'b0) begin errors++; $display("FAIL reset_first_capture_w1: got %b expected 0", q2); end
    endtask

    task automatic test_capture_hold;
        @(negedge CK);
        D = 8'h5A; E = 1'b1; SE = 1'b0;
        @(posedge CK); #1;
        checks++;
        if (q0 !== 8'h5A || q1 !== 8'h5A) begin errors++; $display("FAIL capture: got %h/%h expected 5a", q0, q1); end
        checks++;
        if (gck0 !== 1'b1) begin errors++; $display("FAIL capture_gck: got %b expected 1", gck0); end
        @(negedge CK);
        E = 1'b0; D = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge CK); #1;
            checks++;
            if (q0 !== 8'h5A || q1 !== 8'h5A) begin errors++; $display("FAIL hold_%0d: got %h/%h expected 5a", k, q0, q1); end
            checks++;
            if (gck0 !== 1'b0) begin errors++; $display("FAIL hold_gck_%0d: got %b expected 0", k, gck0); end
        end
    endtask

    task automatic test_scan;
        // Shifting 1,0,1,1 in time order:
        //   toward MSB: 01 -> 02 -> 05 -> 0B ; toward LSB: 80 -> 40 -> A0 -> D0
        logic       bits [4];
        logic [7:0] exp0 [4];
        logic [7:0] exp1 [4];
        bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp0 = '{8'h01, 8'h02, 8'h05, 8'h0B};
        exp1 = '{8'h80, 8'h40, 8'hA0, 8'hD0};
        @(negedge CK);
        E = 1'b1; D = 8'h00; SE = 1'b0;
        @(posedge CK); #1;
        checks++;
        if (q0 !== 8'h00 || q1 !== 8'h00) begin errors++; $display("FAIL scan_clear: got %h/%h expected 00", q0, q1); end
        for (int k = 0; k < 4; k++) begin
            @(negedge CK);
            E = 1'b0; SE = 1'b1; SI = bits[k];
            @(posedge CK); #1;
            checks++;
            if (q0 !== exp0[k]) begin errors++; $display("FAIL scan_msb_%0d: got %h expected %h", k, q0, exp0[k]); end
            checks++;
            if (q1 !== exp1[k]) begin errors++; $display("FAIL scan_lsb_%0d: got %h expected %h", k, q1, exp1[k]); end
            checks++;
            if (q2 !== bits[k] || so2 !== bits[k]) begin errors++; $display("FAIL scan_w1_%0d: got q=%b so=%b expected %b", k, q2, so2, bits[k]); end
        end
        checks++;
        if (so0 !== 1'b0 || so1 !== 1'b0) begin errors++; $display("FAIL scan_so: got %b%b expected 00", so0, so1); end
        @(negedge CK);
        SE = 1'b0; SI = 1'b0;
    endtask

    task automatic test_async_conflict;
        @(negedge CK);
        E = 1'b1; D = 8'h08;
        @(posedge CK); #1;
        checks++;
        if (q0 !== 8'h08 || q1 !== 8'h08) begin errors++; $display("FAIL async_preload: got %h/%h expected 08", q0, q1); end
        // Both async inputs on bit 3 asserted mid-cycle.
        @(negedge CK); #1;
        CLRN[3] = 1'b0; SETN[3] = 1'b0; #1;
        checks++;
        if (q0 !== 8'h00) begin errors++; $display("FAIL async_conflict_clr: got %h expected 00", q0); end
        checks++;
        if (q1 !== 8'h08) begin errors++; $display("FAIL async_conflict_set: got %h expected 08", q1); end
        D = 8'hF7;
        @(posedge CK); #1;
        checks++;
        if (q0 !== 8'hF7 || q1 !== 8'hFF) begin errors++; $display("FAIL async_ignore_d0: got %h/%h expected f7/ff", q0, q1); end
        @(negedge CK);
        D = 8'hFF;
        @(posedge CK); #1;
        checks++;
        if (q0 !== 8'hF7 || q1 !== 8'hFF) begin errors++; $display("FAIL async_ignore_d1: got %h/%h expected f7/ff", q0, q1); end
        // Release mid high phase: forced values hold until the next edge.
        CLRN[3] = 1'b1; SETN[3] = 1'b1; #1;
        checks++;
        if (q0 !== 8'hF7 || q1 !== 8'hFF) begin errors++; $display("FAIL async_release_hold: got %h/%h expected f7/ff", q0, q1); end
        @(negedge CK);
        D = 8'h00;
        @(posedge CK); #1;
        checks++;
        if (q0 !== 8'h00 || q1 !== 8'h00) begin errors++; $display("FAIL async_release_capture: got %h/%h expected 00", q0, q1); end
        // Set alone, then clear alone.
        @(negedge CK); #1;
        SETN[0] = 1'b0; #1;
        checks++;
        if (q0 !== 8'h01 || q1 !== 8'h01) begin errors++; $display("FAIL async_set_only: got %h/%h expected 01", q0, q1); end
        SETN[0] = 1'b1; D = 8'hFF;
        @(posedge CK); #1;
        @(negedge CK); #1;
        CLRN[7] = 1'b0; #1;
        checks++;
        if (q0 !== 8'h7F || q1 !== 8'h7F) begin errors++; $display("FAIL async_clr_only: got %h/%h expected 7f", q0, q1); end
        CLRN[7] = 1'b1;
        E = 1'b0;
    endtask

    task automatic test_icg_glitch;
        int start;
        @(negedge CK);
        D = 8'hAA; E = 1'b0; SE = 1'b0;
        start = gck_pulses;
        // Enable pulse confined to the high phase must not reach GCK.
        @(posedge CK); #1;
        E = 1'b1; #2;
        checks++;
        if (gck0 !== 1'b0) begin errors++; $display("FAIL icg_glitch_gck: got %b expected 0", gck0); end
        E = 1'b0;
        @(posedge CK); #1;
        checks++;
        if (q0 !== 8'h7F || gck_pulses - start !== 0) begin errors++; $display("FAIL icg_glitch_q: got q=%h pulses=%0d expected 7f/0", q0, gck_pulses - start); end
        // Enable during the low phase gives exactly one pulse and one capture.
        @(negedge CK); #1;
        E = 1'b1;
        @(posedge CK); #1;
        checks++;
        if (gck0 !== 1'b1 || q0 !== 8'hAA) begin errors++; $display("FAIL icg_capture: got gck=%b q=%h expected 1/aa", gck0, q0); end
        @(negedge CK); #1;
        E = 1'b0; D = 8'h55;
        repeat (2) @(posedge CK);
        #1;
        checks++;
        if (q0 !== 8'hAA || gck_pulses - start !== 1) begin errors++; $display("FAIL icg_single_pulse: got q=%h pulses=%0d expected aa/1", q0, gck_pulses - start); end
    endtask

    task automatic test_notifier;
        logic [7:0] dv [4];
        logic       nv [4];
        dv = '{8'h11, 8'h22, 8'h33, 8'h44};
        nv = '{1'b0, 1'b1, 1'bx, 1'bz};
        for (int k = 0; k < 4; k++) begin
            @(negedge CK);
            E = 1'b1; D = dv[k]; NOTIFIER = nv[k];
            @(posedge CK);
            NOTIFIER = nv[(k + 1) % 4];
            #1;
            checks++;
            if (q0 !== dv[k] || q1 !== dv[k]) begin errors++; $display("FAIL notifier_%0d: got %h/%h expected %h", k, q0, q1, dv[k]); end
        end
        @(negedge CK);
        NOTIFIER = 1'b0; E = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        RN = 1'b1; CLRN = 8'hFF; SETN = 8'hFF; clrn2 = 1'b1; setn2 = 1'b1;
        E = 1'b0; D = 8'h00; SE = 1'b0; SI = 1'b0; NOTIFIER = 1'b0;
        test_reset();
        test_capture_hold();
        test_scan();
        test_async_conflict();
        test_icg_glitch();
        test_notifier();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
